// File: rtl/fifo_arb_pkg.sv
// Shared width helpers for the credit-based FIFO write arbiter.
package fifo_arb_pkg;

  function automatic int unsigned cred_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Index width for a requester count; never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer handshake plus FIFO write/pop signals seen by the write arbiter.
interface fifo_write_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter type         T     = logic [31:0]
);
  logic [N_REQ-1:0] req_valid;
  T                 req_data [N_REQ];
  logic [N_REQ-1:0] req_ready;
  logic             fifo_write_en;
  T                 fifo_write_data;
  logic             fifo_read_en;
  logic             fifo_empty;
  logic             fifo_full;

  // Environment side: producers, FIFO status and the consumer pop strobe.
  modport master (
    output req_valid, req_data, fifo_read_en, fifo_empty, fifo_full,
    input  req_ready, fifo_write_en, fifo_write_data
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, fifo_read_en, fifo_empty, fifo_full,
    output req_ready, fifo_write_en, fifo_write_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [idx_w(N_REQ)-1:0]  ptr,
  input  logic                     enable,
  output logic [N_REQ-1:0]         grant,
  output logic [idx_w(N_REQ)-1:0]  grant_idx,
  output logic                     any_grant
);
  localparam int unsigned IdxW = idx_w(N_REQ);

  logic [IdxW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = IdxW'((32'(ptr) + off) % N_REQ);
      if (enable && !any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin sharing of one FIFO write port with credit-based backpressure,
// so producer ready never depends combinationally on fifo_full.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter type         T     = logic [31:0],
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  fifo_write_arbiter_if.slave       bus,
  output logic [cred_w(DEPTH)-1:0]  credits,
  output logic                      overflow_err
);
  localparam int unsigned     IdxW    = idx_w(N_REQ);
  localparam int unsigned     CredW   = cred_w(DEPTH);
  localparam logic [CredW-1:0] CredMax = CredW'(DEPTH);
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(N_REQ - 1);

  logic [CredW-1:0] credits_q, credits_d;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic             wr_en_q;
  T                 wr_data_q, wr_data_d;
  logic             overflow_q, overflow_d;

  logic             grant_en;
  logic [N_REQ-1:0] grant;
  logic [IdxW-1:0]  grant_idx;
  logic             any_grant;
  logic             accept;
  logic             pop;

  assign grant_en = (credits_q != '0) & ~flush & ~reset;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_q),
    .enable    (grant_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign bus.req_ready = grant;
  assign accept        = |(bus.req_valid & grant);
  assign pop           = bus.fifo_read_en & ~bus.fifo_empty;

  always_comb begin
    credits_d = credits_q;
    if (accept && !pop) begin
      credits_d = credits_q - CredW'(1);
    end else if (pop && !accept && credits_q != CredMax) begin
      credits_d = credits_q + CredW'(1);
    end

    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == LastIdx) ? '0 : grant_idx + IdxW'(1);
    end

    wr_data_d = accept ? bus.req_data[grant_idx] : wr_data_q;

    // A pop with every slot already free means the consumer popped something never written.
    overflow_d = overflow_q | (wr_en_q & bus.fifo_full)
               | (pop & ~accept & ~flush & (credits_q == CredMax));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q  <= CredMax;
      rr_ptr_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      if (flush) begin
        credits_q <= CredMax;
        rr_ptr_q  <= '0;
        wr_en_q   <= 1'b0;
        wr_data_q <= '0;
      end else begin
        credits_q <= credits_d;
        rr_ptr_q  <= rr_ptr_d;
        wr_en_q   <= accept;
        wr_data_q <= wr_data_d;
      end
    end
  end

  assign bus.fifo_write_en   = wr_en_q;
  assign bus.fifo_write_data = wr_data_q;
  assign credits             = credits_q;
  assign overflow_err        = overflow_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: reference model plus data scoreboard around fifo_write_arbiter.
module tb_fifo_write_arbiter;
  localparam int unsigned NReq  = 4;
  localparam int unsigned Depth = 8;
  typedef logic [31:0] data_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [3:0] credits;
  logic       overflow_err;
  logic       empty_ovr;
  int         occ;

  fifo_write_arbiter_if #(.N_REQ(NReq), .T(data_t)) bus ();

  fifo_write_arbiter #(
    .T     (data_t),
    .N_REQ (NReq),
    .DEPTH (Depth)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .bus          (bus.slave),
    .credits      (credits),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  // Occupancy model of the downstream FIFO; empty_ovr fakes a non-empty FIFO.
  always @(posedge clk) begin
    if (reset || flush) occ <= 0;
    else occ <= occ + (bus.fifo_write_en ? 1 : 0) - ((bus.fifo_read_en && occ != 0) ? 1 : 0);
  end
  assign bus.fifo_empty = (occ == 0) && !empty_ovr;
  assign bus.fifo_full  = (occ >= Depth);

  int    errors = 0;
  int    checks = 0;
  int    m_ptr, m_cred;
  logic  m_wr, m_ovf, m_known;
  data_t exp_q[$];
  int    gnt_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    int         g;
    logic [3:0] exp_rdy;
    logic       acc, pop;
    int         n_ptr, n_cred;
    logic       n_wr, n_ovf;
    data_t      d;
    #1;
    g = -1;
    exp_rdy = '0;
    if (!reset && !flush && m_cred != 0) begin
      for (int k = 0; k < NReq; k++) begin
        int idx;
        idx = (m_ptr + k) % NReq;
        if (g < 0 && bus.req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    for (int k = 0; k < NReq; k++)
      if (bus.req_ready[k] && bus.req_valid[k]) gnt_log.push_back(k);
    if (m_known) begin
      check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      check_eq("credits", 32'(credits), m_cred);
      check_eq("overflow_err", 32'(overflow_err), 32'(m_ovf));
    end
    acc = (g >= 0);
    pop = bus.fifo_read_en && !bus.fifo_empty;
    if (acc) exp_q.push_back(bus.req_data[g]);
    if (reset) begin
      n_cred = Depth; n_ptr = 0; n_wr = 1'b0; n_ovf = 1'b0;
    end else if (flush) begin
      n_cred = Depth; n_ptr = 0; n_wr = 1'b0;
      n_ovf  = m_ovf | (m_wr & bus.fifo_full);
    end else begin
      n_ovf  = m_ovf | (m_wr & bus.fifo_full) | (pop && !acc && m_cred == Depth);
      n_wr   = acc;
      n_ptr  = acc ? (g + 1) % NReq : m_ptr;
      n_cred = m_cred;
      if (acc && !pop) n_cred = m_cred - 1;
      else if (pop && !acc && m_cred < Depth) n_cred = m_cred + 1;
    end
    @(posedge clk);
    m_cred = n_cred; m_ptr = n_ptr; m_wr = n_wr; m_ovf = n_ovf;
    if (reset) m_known = 1'b1;
    #1;
    check_eq("fifo_write_en", 32'(bus.fifo_write_en), 32'(m_wr));
    if (bus.fifo_write_en && m_wr) begin
      if (exp_q.size() == 0) begin
        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        d = exp_q.pop_front();
        check_eq("fifo_write_data", bus.fifo_write_data, d);
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.req_valid = '0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; empty_ovr = 1'b0;
    bus.req_valid = '0; bus.fifo_read_en = 1'b0;
    for (int i = 0; i < NReq; i++) bus.req_data[i] = '0;
    m_ptr = 0; m_cred = Depth; m_wr = 1'b0; m_ovf = 1'b0; m_known = 1'b0;

    // 1: two producers share the port until credits run out
    do_reset(3);
    check_eq("reset_credits", 32'(credits), 32'd8);
    check_eq("reset_ready", 32'(bus.req_ready), 32'd0);
    bus.req_data[0] = 32'd5; bus.req_data[2] = 32'd7;
    bus.req_valid = 4'b0101;
    gnt_log.delete();
    repeat (10) tick();
    check_eq("t1_grant_count", 32'(gnt_log.size()), 32'd8);
    for (int i = 0; i < gnt_log.size(); i++)
      check_eq("t1_grant_order", 32'(gnt_log[i]), (i % 2 == 1) ? 32'd2 : 32'd0);
    check_eq("t1_credits_zero", 32'(credits), 32'd0);
    check_eq("t1_fifo_full", 32'(bus.fifo_full), 32'd1);
    check_eq("t1_no_overflow", 32'(overflow_err), 32'd0);

    // 2: all requesters valid starting from rr_ptr=3
    do_reset(1);
    for (int i = 0; i < NReq; i++) bus.req_data[i] = 32'h100 + 32'(i);
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = 4'b1111;
    gnt_log.delete();
    repeat (5) tick();
    check_eq("t2_grant_count", 32'(gnt_log.size()), 32'd5);
    for (int i = 0; i < gnt_log.size(); i++)
      check_eq("t2_grant_order", 32'(gnt_log[i]), 32'((3 + i) % NReq));

    // 3: single pop at zero credits releases exactly one grant
    do_reset(1);
    bus.req_valid = 4'b1111;
    repeat (10) tick();
    bus.fifo_read_en = 1'b1;
    tick();
    bus.fifo_read_en = 1'b0;
    check_eq("t3_credit_back", 32'(credits), 32'd1);
    gnt_log.delete();
    repeat (3) tick();
    check_eq("t3_one_grant", 32'(gnt_log.size()), 32'd1);
    check_eq("t3_credits_zero", 32'(credits), 32'd0);

    // 4: simultaneous accept and pop keeps credits steady
    do_reset(1);
    bus.req_data[0] = 32'hA5A5_0000;
    bus.req_valid = 4'b0001;
    repeat (4) tick();
    bus.fifo_read_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("t4_credits_hold", 32'(credits), 32'd4);
    end
    bus.fifo_read_en = 1'b0;
    bus.req_valid = '0;
    tick();

    // 5: flush drops the staged write and restarts the pointer at 0
    do_reset(1);
    bus.req_data[0] = 32'hC0; bus.req_data[1] = 32'hC1;
    bus.req_valid = 4'b0001;
    tick();
    flush = 1'b1;
    bus.req_valid = 4'b0011;
    tick();
    flush = 1'b0;
    check_eq("t5_no_write", 32'(bus.fifo_write_en), 32'd0);
    check_eq("t5_credits", 32'(credits), 32'd8);
    gnt_log.delete();
    tick();
    check_eq("t5_first_grant", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'hFFFF_FFFF, 32'd0);
    bus.req_valid = '0;
    tick();

    // 6: pop at full credits is sticky through flush, cleared by reset
    do_reset(1);
    empty_ovr = 1'b1;
    bus.fifo_read_en = 1'b1;
    tick();
    empty_ovr = 1'b0;
    bus.fifo_read_en = 1'b0;
    check_eq("t6_overflow_set", 32'(overflow_err), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check_eq("t6_sticky_flush", 32'(overflow_err), 32'd1);
    do_reset(1);
    tick();
    check_eq("t6_reset_clears", 32'(overflow_err), 32'd0);

    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
